// File: rtl/sd_arbiter.sv
// Round-robin arbiter sharing one host SD sector port among NUM_REQ track loaders; optional abort via SD_ARB_TIMEOUT_EN.
// Latency: request to command 1 cycle, ack fall to idle 1 cycle; ack/buff_wr/buff_din routing is combinational.
// Backpressure: a grant is held until the sector transfer ends; other requesters simply keep their levels asserted.
module sd_arbiter #(
  parameter int          NUM_REQ        = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_rd,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [32*NUM_REQ-1:0]  req_lba,
  input  logic [8*NUM_REQ-1:0]   req_buff_din,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_buff_wr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din,
  output logic [1:0]             sd_id,
  output logic                   busy,
  output logic                   timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic        busy_q, busy_d;
  logic        old_ack_q, old_ack_d;

  logic [NUM_REQ-1:0] pend;
  logic        hi_found, lo_found, found;
  logic [1:0]  hi_idx, lo_idx, winner;
  logic [31:0] win_lba;
  logic        win_rd, win_wr;

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        cnt_hit;
  assign cnt_hit = (cnt_q + 24'd1 == TIMEOUT_CYCLES);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Rotating priority: first pending index above last wins, else wrap to the lowest pending one.
  always_comb begin
    pend     = req_rd | req_wr;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = 2'd0;
    lo_idx   = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        if (2'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = 2'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = 2'(i);
        end
      end
    end
    found  = hi_found | lo_found;
    winner = hi_found ? hi_idx : lo_idx;
    win_lba = 32'd0;
    win_rd  = 1'b0;
    win_wr  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 2'(i)) begin
        win_lba = req_lba[32*i +: 32];
        win_rd  = req_rd[i];
        win_wr  = req_wr[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    sd_lba_d  = sd_lba_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    busy_d    = busy_q;
    old_ack_d = sd_ack;
`ifdef SD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = winner;
          busy_d   = 1'b1;
          sd_lba_d = win_lba;
          sd_wr_d  = win_wr;
          sd_rd_d  = win_rd & ~win_wr;
          state_d  = ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
          cnt_d    = 24'd0;
`endif
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
`ifdef SD_ARB_TIMEOUT_EN
        end else if (cnt_hit) begin
          // Abort: no ack was ever routed, so the requester is still asserting and re-arbitrates.
          sd_rd_d   = 1'b0;
          sd_wr_d   = 1'b0;
          timeout_d = 1'b1;
          last_d    = grant_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
`endif
        end
      end
      XFER: begin
        if (old_ack_q && !sd_ack) begin
          last_d  = grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      last_q    <= 2'(NUM_REQ - 1);
      sd_lba_q  <= 32'd0;
      sd_rd_q   <= 1'b0;
      sd_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      old_ack_q <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q     <= 24'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      sd_lba_q  <= sd_lba_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      busy_q    <= busy_d;
      old_ack_q <= old_ack_d;
`ifdef SD_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Host strobes reach only the granted requester, and only while a grant is live.
  always_comb begin
    req_ack     = '0;
    req_buff_wr = '0;
    sd_buff_din = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        sd_buff_din = req_buff_din[8*i +: 8];
        if (busy_q) begin
          req_ack[i]     = sd_ack;
          req_buff_wr[i] = sd_buff_wr & sd_ack;
        end
      end
    end
  end

  assign sd_lba = sd_lba_q;
  assign sd_rd  = sd_rd_q;
  assign sd_wr  = sd_wr_q;
  assign sd_id  = grant_q;
  assign busy   = busy_q;
`ifdef SD_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/sd_arbiter.md
# sd_arbiter

Arbiter sharing one host SD block-transfer port (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between up to four track-buffer controllers, e.g. drives 8 and 9. It sits between the host block-device interface and the per-drive track loaders. Each requester issues single-sector read or write requests. The arbiter grants requests round-robin, forwards the LBA and command, and routes ack, buffer writes and buffer read data to the granted requester only. A grant is held until that sector transfer completes.

## Interface
- NUM_REQ, 2, number of requesters, legal 2..4
- TIMEOUT_CYCLES, 24'd10_000_000, cycles without sd_ack before abort; used only with SD_ARB_TIMEOUT_EN
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; one clock
- req_rd  in  NUM_REQ  per-requester read request; level, held until its req_ack rises
- req_wr  in  NUM_REQ  per-requester write request; same rules as req_rd
- req_lba  in  32*NUM_REQ  packed LBAs; requester i uses bits [32i+31:32i]
- req_buff_din  in  8*NUM_REQ  packed write-data bytes from requesters
- req_ack  out  NUM_REQ  sd_ack routed to the granted requester
- req_buff_wr  out  NUM_REQ  sd_buff_wr routed to the granted requester
- sd_lba  out  32  LBA to host
- sd_rd, sd_wr  out  1 each  command to host
- sd_ack  in  1  host transfer acknowledge
- sd_buff_wr  in  1  host buffer write strobe
- sd_buff_din  out  8  byte to host, muxed from the granted requester
- sd_id  out  2  index of the granted requester
- busy  out  1  a grant is active
- timeout  out  1  one-cycle abort pulse; constant 0 without the macro

sd_buff_addr and sd_buff_dout are broadcast and wired directly to all requesters. They do not pass through this block.

## Operation
- States: IDLE, ISSUE, XFER.
- **IDLE**
  - pend[i] = req_rd[i] | req_wr[i].
  - If any pend bit is set, pick the winner: the first set index scanning from last+1 modulo NUM_REQ.
  - Next cycle: grant = winner, sd_id = winner, busy = 1, sd_lba = req_lba[winner].
  - sd_wr = req_wr[winner]; sd_rd = req_rd[winner] & ~req_wr[winner]. Write wins when both are set.
  - Go to ISSUE.
- **ISSUE**
  - Hold sd_lba and the command.
  - When sd_ack = 1: clear sd_rd and sd_wr in the next cycle and go to XFER.
- **XFER**
  - On sd_ack falling (registered old_ack = 1, sd_ack = 0): set last = grant, busy = 0, return to IDLE.
- **Routing**
  - req_ack[i] = sd_ack & busy & (grant == i).
  - req_buff_wr[i] = sd_buff_wr & sd_ack & busy & (grant == i).
  - sd_buff_din = req_buff_din[grant]. All three are combinational.
- **Latching**
  - sd_lba and the command are latched at grant.
  - Requester changes to req_lba, req_rd or req_wr after grant are ignored until the next IDLE.
- **Boundary conditions**
  - sd_ack while IDLE: ignored, not routed, no state change.
  - Requester drops its request before sd_ack: the transfer still runs to completion and is not cancelled.
  - All requesters pending continuously: strict rotation 0,1,..,NUM_REQ-1,0.
  - Single requester re-requesting: it is re-granted on the first IDLE cycle where it is pending.
  - Reset mid-transfer: enter IDLE immediately, route nothing; a host ack still in flight is ignored.

## Timing
- Reset values:
  - sd_rd = 0, sd_wr = 0, busy = 0, timeout = 0, sd_lba = 0, sd_id = 0.
  - grant = 0, last = NUM_REQ-1, so requester 0 has first priority.
- Request to sd_rd/sd_wr: 1 cycle (request sampled in IDLE at edge N, command visible after edge N+1).
- sd_ack rise to command cleared: 1 cycle.
- sd_ack fall to busy = 0: 1 cycle.
- Earliest re-arbitration is in the IDLE cycle that follows, so there is a minimum 1 idle cycle between grants.
- Routed outputs (req_ack, req_buff_wr, sd_buff_din) have zero latency.

## Configuration
- SD_ARB_TIMEOUT_EN defined:
  - A 24-bit counter clears on entry to ISSUE and counts while in ISSUE.
  - On reaching TIMEOUT_CYCLES: clear sd_rd and sd_wr, pulse timeout for 1 cycle, set last = grant, return to IDLE.
  - The aborted requester sees no req_ack and keeps requesting; it is re-arbitrated normally.
- SD_ARB_TIMEOUT_EN undefined: no counter, timeout tied to 0, ISSUE waits indefinitely.

## Test plan
- After reset, req_rd[1] = 1 with req_lba1 = 0x15:
  - sd_rd = 1, sd_lba = 0x15 and sd_id = 1 one cycle later.
  - Ack held 4 cycles: req_ack = 2'b10 for exactly those 4 cycles.
  - busy = 0 one cycle after the ack falls.
- req_rd = 2'b11 held continuously with 10 completed transfers: grants alternate 0,1,0,1, …; 5 transfers per requester.
- req_rd[0] = 1 and req_wr[0] = 1 together: sd_wr = 1, sd_rd = 0. During ack, 512 sd_buff_wr strobes:
  - req_buff_wr[0] pulses 512 times, req_buff_wr[1] never.
  - sd_buff_din tracks req_buff_din0.
- sd_ack pulsed while IDLE: no req_ack, busy stays 0. Changing req_lba0 after grant: sd_lba unchanged.
- reset_n low during XFER with sd_ack still high: next cycle busy = 0, req_ack = 0, sd_rd = sd_wr = 0. After reset, requester 0 has priority.
- With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100, no ack: timeout pulses once 100 cycles after entering ISSUE, then the other pending requester is granted next.
